tape_ram_writer: RTL and testbench

Buffers the byte-write stream produced by the cassette TAP parser (`tape_addr`/`tape_wr`/`tape_dout`/`tape_complete`) and replays it into the shared Lynx main-RAM write port during cycles the CPU does not own. It sits directly downstream of the cassette parser and upstream of the RAM bank mux. It turns the parser's level-held `tape_wr` into discrete one-cycle RAM writes, queues up to DEPTH pending writes, and reports load progress and completion.

---
 rtl/tape_pkg.sv | 20 ++
 rtl/tape_wr_fifo.sv | 62 ++++++
 rtl/tape_ram_writer.sv | 146 ++++++++++++++
 tb/tb_tape_ram_writer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tape_pkg.sv
// Shared types and constants for the cassette-to-RAM write path.
package tape_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOADING  = 2'd1,
    ST_DRAINING = 2'd2,
    ST_DONE     = 2'd3
  } tape_state_e;

  localparam int          DEFAULT_DEPTH  = 16;
  localparam int          DEFAULT_ADDR_W = 16;
  localparam int          ENTRY_W        = DEFAULT_ADDR_W + 8;
  localparam logic [15:0] LYNX_LOAD_ADDR = 16'h694D;

  function automatic int entry_width(input int addr_w);
    return addr_w + 8;
  endfunction

endpackage

// File: rtl/tape_wr_fifo.sv
// Small synchronous FIFO for pending tape bytes; a push into a full FIFO
// succeeds when a pop happens in the same cycle.
module tape_wr_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]  CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]  CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = (PTR_W)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_FULL);
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tape_ram_writer.sv
// Turns the TAP parser's level-held byte writes into one-cycle RAM writes,
// replayed in CPU-free cycles, with load progress and completion status.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | after reset, waiting for the first byte of a file
// LOADING  | bytes arriving and draining; waiting for tape_complete edge
// DRAINING | file finished, flushing the queued bytes into RAM
// DONE     | every byte of the file has been written to RAM
module tape_ram_writer
  import tape_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] tape_addr,
  input  logic              tape_wr,
  input  logic [7:0]        tape_dout,
  input  logic              tape_complete,
  input  logic              cpu_mem_req,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_din,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [15:0]       byte_count
);

  localparam int EW = entry_width(ADDR_W);

  tape_state_e       state_q, state_d;
  logic              prev_wr_q;
  logic              prev_cmp_q;
  logic [ADDR_W-1:0] last_addr_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [7:0]        ram_din_q;
  logic              ram_we_q;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       byte_count_q, byte_count_d;

  logic              new_byte;
  logic              cmp_rise;
  logic              pop;
  logic              push_ok;
  logic              fifo_full;
  logic              fifo_empty;
  logic [EW-1:0]     head;

  // A held tape_wr only counts again when the parser moves to a new address.
  assign new_byte = tape_wr && (!prev_wr_q || (tape_addr != last_addr_q));
  assign cmp_rise = tape_complete && !prev_cmp_q;
  assign pop      = !fifo_empty && !cpu_mem_req;
  assign push_ok  = new_byte && (!fifo_full || pop);

  tape_wr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push_ok),
    .wdata_i ({tape_addr, tape_dout}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    byte_count_d = byte_count_q;
    overflow_d   = overflow_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (push_ok) begin
          state_d      = ST_LOADING;
          byte_count_d = 16'd1;
          overflow_d   = 1'b0;
        end
      end
      ST_LOADING, ST_DRAINING: begin
        if (push_ok) begin
          byte_count_d = byte_count_q + 16'd1;
        end else if (new_byte) begin
          overflow_d = 1'b1;
        end
        if (state_q == ST_LOADING && cmp_rise) begin
          state_d = ST_DRAINING;
        end
        // Empty with nothing arriving means the last write is on the port now.
        if (state_q == ST_DRAINING && fifo_empty && !push_ok) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_LOADING) || (state_d == ST_DRAINING);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      prev_wr_q    <= 1'b0;
      prev_cmp_q   <= 1'b0;
      last_addr_q  <= '0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      ram_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      prev_wr_q    <= tape_wr;
      prev_cmp_q   <= tape_complete;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
      byte_count_q <= byte_count_d;
      ram_we_q     <= pop;
      if (push_ok) begin
        last_addr_q <= tape_addr;
      end
      if (pop) begin
        ram_addr_q <= head[EW-1:8];
        ram_din_q  <= head[7:0];
      end
    end
  end

  assign ram_addr   = ram_addr_q;
  assign ram_din    = ram_din_q;
  assign ram_we     = ram_we_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_tape_ram_writer.sv
// Randomized + directed bench for tape_ram_writer with a queue-based
// reference model and a scoreboard monitor on the RAM write port.
module tb_tape_ram_writer;
  import tape_pkg::*;

  localparam int DEPTH = 16;
  localparam int P_IDLE = 0, P_LOAD = 1, P_DRAIN = 2, P_DONE = 3;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } ent_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } dchk_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] tape_addr = '0;
  logic        tape_wr = 1'b0;
  logic [7:0]  tape_dout = '0;
  logic        tape_complete = 1'b0;
  logic        cpu_mem_req = 1'b0;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] byte_count;

  tape_ram_writer #(.DEPTH(DEPTH), .ADDR_W(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .tape_addr     (tape_addr),
    .tape_wr       (tape_wr),
    .tape_dout     (tape_dout),
    .tape_complete (tape_complete),
    .cpu_mem_req   (cpu_mem_req),
    .ram_addr      (ram_addr),
    .ram_we        (ram_we),
    .ram_din       (ram_din),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .byte_count    (byte_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  ent_t        m_q[$];
  ent_t        sb[$];
  dchk_t       dq[$];
  bit          m_prev_wr, m_prev_cmp, mon_en;
  logic [15:0] m_last;
  int          phase;
  logic        exp_we, exp_ovf;
  logic [15:0] exp_addr, exp_cnt;
  logic [7:0]  exp_din;
  int          n_cmp = 0;
  int          n_bad = 0;

  // The model advances once per rising edge using the inputs seen at that edge.
  always @(posedge clk) begin
    bit newb, acc, popd;
    ent_t e;
    mon_en = 1'b1;
    if (!reset_n) begin
      m_q.delete();
      sb.delete();
      m_prev_wr = 0; m_prev_cmp = 0; m_last = '0; phase = P_IDLE;
      exp_we = 0; exp_addr = '0; exp_din = '0; exp_cnt = '0; exp_ovf = 0;
    end else begin
      newb = tape_wr && (!m_prev_wr || tape_addr != m_last);
      popd = (m_q.size() > 0) && !cpu_mem_req;
      acc  = newb && ((m_q.size() < DEPTH) || popd);
      if (phase == P_DRAIN && m_q.size() == 0 && !acc) phase = P_DONE;
      exp_we = popd;
      if (popd) begin
        e = m_q.pop_front();
        sb.push_back(e);
        exp_addr = e.addr;
        exp_din  = e.data;
      end
      if (acc) begin
        m_q.push_back('{tape_addr, tape_dout});
        m_last = tape_addr;
      end
      if (phase == P_IDLE || phase == P_DONE) begin
        if (acc) begin phase = P_LOAD; exp_cnt = 16'd1; exp_ovf = 0; end
      end else begin
        if (acc) exp_cnt = exp_cnt + 16'd1;
        else if (newb) exp_ovf = 1;
        if (phase == P_LOAD && tape_complete && !m_prev_cmp) phase = P_DRAIN;
      end
      m_prev_wr  = tape_wr;
      m_prev_cmp = tape_complete;
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: all comparisons happen here, away from the rising edge.
  always @(negedge clk) begin
    dchk_t d;
    ent_t  e;
    while (dq.size() > 0) begin
      d = dq.pop_front();
      cmp(d.name, d.act, d.exp);
    end
    if (mon_en) begin
      cmp("ram_we", 32'(ram_we), 32'(exp_we));
      if (ram_we) begin
        if (sb.size() == 0) begin
          cmp("unexpected_write", 32'(ram_we), 32'd0);
        end else begin
          e = sb.pop_front();
          cmp("write_addr", 32'(ram_addr), 32'(e.addr));
          cmp("write_data", 32'(ram_din), 32'(e.data));
        end
      end else begin
        cmp("hold_addr", 32'(ram_addr), 32'(exp_addr));
        cmp("hold_data", 32'(ram_din), 32'(exp_din));
      end
      cmp("busy", 32'(busy), 32'(phase == P_LOAD || phase == P_DRAIN));
      cmp("done", 32'(done), 32'(phase == P_DONE));
      cmp("overflow", 32'(overflow), 32'(exp_ovf));
      cmp("byte_count", 32'(byte_count), 32'(exp_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_eq(input string n, input logic [31:0] a, input logic [31:0] e);
    dq.push_back('{n, a, e});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_done(input string n, input int budget);
    for (int i = 0; i < budget && !done; i++) tick();
    expect_eq(n, 32'(done), 32'd1);
  endtask

  initial begin
    tick(); tick();
    reset_n = 1'b1;
    expect_eq("rst_count", 32'(byte_count), 32'd0);
    expect_eq("rst_busy", 32'(busy), 32'd0);

    // Single byte at the Lynx load address: write appears two edges later.
    tape_addr = LYNX_LOAD_ADDR; tape_dout = 8'hAA; tape_wr = 1'b1;
    tick();
    expect_eq("single_n1_we", 32'(ram_we), 32'd0);
    tape_wr = 1'b0;
    tick();
    expect_eq("single_n2_we", 32'(ram_we), 32'd1);
    expect_eq("single_addr", 32'(ram_addr), 32'h694D);
    expect_eq("single_data", 32'(ram_din), 32'hAA);
    expect_eq("single_count", 32'(byte_count), 32'd1);
    expect_eq("single_busy", 32'(busy), 32'd1);
    tick(); tick();

    // Held level with unchanged address
    tape_addr = 16'h7000; tape_dout = 8'h55; tape_wr = 1'b1;
    repeat (10) tick();
    tape_wr = 1'b0;
    repeat (4) tick();

    // Stall: bytes queue behind CPU ownership, then stream out in order
    cpu_mem_req = 1'b1;
    tape_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tape_addr = 16'h694D + 16'(i); tape_dout = 8'(i + 1);
      tick();
    end
    tape_wr = 1'b0;
    repeat (15) tick();
    expect_eq("stall_no_we", 32'(ram_we), 32'd0);
    cpu_mem_req = 1'b0;
    repeat (10) tick();

    // Overflow in a fresh session
    do_reset();
    cpu_mem_req = 1'b1;
    tape_wr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tape_addr = 16'h8000 + 16'(i); tape_dout = 8'(8'h30 + i);
      tick();
    end
    tape_wr = 1'b0;
    tick();
    expect_eq("ovf_flag", 32'(overflow), 32'd1);
    expect_eq("ovf_count", 32'(byte_count), 32'd16);
    cpu_mem_req = 1'b0;
    repeat (20) tick();

    // Completion with three bytes queued, then restart
    cpu_mem_req = 1'b1;
    tape_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tape_addr = 16'h9000 + 16'(i); tape_dout = 8'(8'hC0 + i);
      tick();
    end
    tape_wr = 1'b0;
    tape_complete = 1'b1;
    cpu_mem_req = 1'b0;
    wait_done("complete_done", 50);
    expect_eq("complete_busy", 32'(busy), 32'd0);
    tape_addr = 16'hA000; tape_dout = 8'h11; tape_wr = 1'b1;
    tick();
    tape_wr = 1'b0;
    expect_eq("restart_done", 32'(done), 32'd0);
    expect_eq("restart_count", 32'(byte_count), 32'd1);
    expect_eq("restart_ovf", 32'(overflow), 32'd0);
    tape_complete = 1'b0;
    repeat (3) tick();

    // Reset in the middle of a drain
    cpu_mem_req = 1'b1;
    tape_wr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tape_addr = 16'hB000 + 16'(i); tape_dout = 8'(8'hE0 + i);
      tick();
    end
    tape_wr = 1'b0;
    cpu_mem_req = 1'b0;
    tick(); tick();
    reset_n = 1'b0;
    tick();
    expect_eq("rst_mid_we", 32'(ram_we), 32'd0);
    expect_eq("rst_mid_addr", 32'(ram_addr), 32'd0);
    expect_eq("rst_mid_count", 32'(byte_count), 32'd0);
    reset_n = 1'b1;
    repeat (10) tick();

    // Randomized sessions
    for (int s = 0; s < 6; s++) begin
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(99) < 20) tape_wr = ~tape_wr;
        if ($urandom_range(99) < 40) tape_addr = 16'h694D + 16'($urandom_range(7));
        tape_dout = 8'($urandom);
        cpu_mem_req = ($urandom_range(99) < 35);
        if ($urandom_range(99) < 3) tape_complete = ~tape_complete;
        reset_n = !($urandom_range(999) < 3);
        tick();
      end
      reset_n = 1'b1; tape_wr = 1'b0; cpu_mem_req = 1'b0; tape_complete = 1'b0;
      tick();
      tape_wr = 1'b1; tape_addr = 16'hC000 + 16'(s);
      tick();
      tape_wr = 1'b0;
      tape_complete = 1'b1;
      wait_done("rand_done", 100);
      tape_complete = 1'b0;
      tick();
    end

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
